// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and baud divisor helper.
// Imported by uart_tx, uart_rx and uart_baud_gen.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
// A sync clear restarts the period so every bit begins on a fresh count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign bit_tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// The line is driven from a flop that updates together with the state, so it is glitch-free.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [7:0] DATA_MASK    = 8'hFF >> (8 - DATA_BITS);
  localparam logic [2:0] LAST_DATA    = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP    = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t state;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        parity_bit;
  logic        line;
  logic        done;
  logic        bit_tick;
  logic        accept;
  logic [7:0]  data_masked;
  logic        data_xor;
  logic        parity_next;

  assign tx_ready    = (state == ST_IDLE);
  assign tx_busy     = (state != ST_IDLE);
  assign tx_done     = done;
  assign uart_tx_out = line;
  assign accept      = tx_valid && tx_ready;

  assign data_masked = tx_data & DATA_MASK;
  assign data_xor    = ^data_masked;
  // data_xor is 1 when the data already holds an odd number of ones
  assign parity_next = (PARITY == PARITY_ODD) ? ~data_xor : data_xor;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (tx_busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      parity_bit <= 1'b0;
      line       <= 1'b1;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          line <= 1'b1;
          if (accept) begin
            shift_reg  <= data_masked;
            parity_bit <= parity_next;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            line       <= 1'b0;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            line      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_DATA) begin
              if (PARITY != PARITY_NONE) begin
                line  <= parity_bit;
                state <= ST_PARITY;
              end else begin
                line  <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              line      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            line  <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (stop_idx == LAST_STOP) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          line  <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 instance plus even- and odd-parity instances.
// Frames are compared cycle by cycle against hand-computed bit patterns.
module tb_uart_tx;

  localparam int CPB = 434;

  logic       clk;
  logic       rst;
  logic [7:0] data_s  [3];
  logic       valid_s [3];
  logic       ready_s [3];
  logic       line_s  [3];
  logic       busy_s  [3];
  logic       done_s  [3];

  int checks = 0;
  int errors = 0;

  uart_tx #(.PARITY(0)) dut (
    .clk(clk), .rst(rst), .tx_data(data_s[0]), .tx_valid(valid_s[0]), .tx_ready(ready_s[0]),
    .uart_tx_out(line_s[0]), .tx_busy(busy_s[0]), .tx_done(done_s[0])
  );

  uart_tx #(.PARITY(2)) dut_even (
    .clk(clk), .rst(rst), .tx_data(data_s[1]), .tx_valid(valid_s[1]), .tx_ready(ready_s[1]),
    .uart_tx_out(line_s[1]), .tx_busy(busy_s[1]), .tx_done(done_s[1])
  );

  uart_tx #(.PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(data_s[2]), .tx_valid(valid_s[2]), .tx_ready(ready_s[2]),
    .uart_tx_out(line_s[2]), .tx_busy(busy_s[2]), .tx_done(done_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  // frame bits are listed in line order: bit 0 is the start bit
  typedef struct {
    int          u;
    logic [7:0]  data;
    logic [11:0] frame;
    int          nbits;
    string       name;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // samples every cycle of the frame, starting with the cycle after acceptance
  task automatic check_bits(input int u, input logic [11:0] fr, input int nbits, input string nm);
    int bad;
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (line_s[u] !== fr[b]) bad++;
        if (done_s[u] !== 1'b0) bad++;
        if (ready_s[u] !== 1'b0) bad++;
        if (busy_s[u] !== 1'b1) bad++;
      end
      chk($sformatf("%s slot%0d bad cycles", nm, b), bad, 0);
    end
  endtask

  task automatic check_done(input int u, input string nm);
    @(negedge clk);
    chk({nm, " done pulse"}, done_s[u], 1);
    chk({nm, " ready at done"}, ready_s[u], 1);
    chk({nm, " line at done"}, line_s[u], 1);
    @(negedge clk);
    chk({nm, " done single cycle"}, done_s[u], 0);
  endtask

  task automatic send_frame(input int u, input logic [7:0] d, input logic [11:0] fr,
                            input int nbits, input string nm);
    @(negedge clk);
    chk({nm, " ready before"}, ready_s[u], 1);
    valid_s[u] = 1'b1;
    data_s[u]  = d;
    @(posedge clk);
    #1;
    valid_s[u] = 1'b0;
    data_s[u]  = ~d;
    check_bits(u, fr, nbits, nm);
    check_done(u, nm);
  endtask

  initial begin
    int n_done;

    vecs[0] = '{0, 8'h55, 12'h2AA, 10, "8n1 0x55"};
    vecs[1] = '{0, 8'hA5, 12'h34A, 10, "8n1 0xA5"};
    vecs[2] = '{0, 8'h00, 12'h200, 10, "8n1 0x00"};
    vecs[3] = '{0, 8'hFF, 12'h3FE, 10, "8n1 0xFF"};
    vecs[4] = '{1, 8'h07, 12'h60E, 11, "8e1 0x07"};
    vecs[5] = '{2, 8'h07, 12'h40E, 11, "8o1 0x07"};

    for (int i = 0; i < 3; i++) begin
      valid_s[i] = 1'b0;
      data_s[i]  = 8'h00;
    end

    // reset must win over a pending tx_valid
    rst        = 1'b1;
    valid_s[0] = 1'b1;
    data_s[0]  = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset line", line_s[0], 1);
    chk("reset ready", ready_s[0], 1);
    chk("reset busy", busy_s[0], 0);
    chk("reset done", done_s[0], 0);
    valid_s[0] = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    chk("idle line", line_s[0], 1);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].u, vecs[i].data, vecs[i].frame, vecs[i].nbits, vecs[i].name);
    end

    // back-to-back with tx_valid held: 0x01 then 0x80
    @(negedge clk);
    valid_s[0] = 1'b1;
    data_s[0]  = 8'h01;
    @(posedge clk);
    #1;
    data_s[0] = 8'h80;
    check_bits(0, 12'h202, 10, "b2b 0x01");
    @(negedge clk);
    chk("b2b gap done", done_s[0], 1);
    chk("b2b gap ready", ready_s[0], 1);
    chk("b2b gap line", line_s[0], 1);
    @(posedge clk);
    #1;
    valid_s[0] = 1'b0;
    check_bits(0, 12'h300, 10, "b2b 0x80");
    check_done(0, "b2b 0x80");
    chk("b2b no third frame", busy_s[0], 0);

    // tx_valid pulse with 0x3C during data bit 2 must be ignored
    @(negedge clk);
    valid_s[0] = 1'b1;
    data_s[0]  = 8'h96;
    @(posedge clk);
    #1;
    valid_s[0] = 1'b0;
    fork
      check_bits(0, 12'h32C, 10, "ignore 0x96");
      begin
        repeat (3 * CPB + 200) @(negedge clk);
        valid_s[0] = 1'b1;
        data_s[0]  = 8'h3C;
        @(negedge clk);
        valid_s[0] = 1'b0;
      end
    join
    check_done(0, "ignore 0x96");
    chk("ignore no extra frame", busy_s[0], 0);

    // reset during data bit 3 of 0xF0 (that bit is low on the line)
    @(negedge clk);
    valid_s[0] = 1'b1;
    data_s[0]  = 8'hF0;
    @(posedge clk);
    #1;
    valid_s[0] = 1'b0;
    repeat (4 * CPB + 100) @(negedge clk);
    chk("midreset line before", line_s[0], 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset line", line_s[0], 1);
    chk("midreset ready", ready_s[0], 1);
    chk("midreset busy", busy_s[0], 0);
    chk("midreset done", done_s[0], 0);
    rst    = 1'b0;
    n_done = 0;
    for (int c = 0; c < 7 * CPB; c++) begin
      @(negedge clk);
      if (done_s[0] === 1'b1 || line_s[0] !== 1'b1) n_done++;
    end
    chk("midreset quiet line", n_done, 0);
    send_frame(0, 8'h5A, 12'h2B4, 10, "after reset 0x5A");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
